// File: rtl/instr_encoder.sv
// Encodes RV32 instruction field bundles into 32-bit words and queues them in an
// output FIFO; the head word is presented together with its byte address.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic        mul,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] pop_count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_B = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          live;
    logic          full;
    logic          empty;
    logic          fmt_legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   enc_word;

    always_comb begin
        enc_word  = 32'h0;
        fmt_legal = 1'b1;
        case (fmt)
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                // SLLI/SRLI/SRAI: the upper immediate bits carry the shift-type select
                if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
                    enc_word[31:25] = {1'b0, f7b5, 5'b0};
            end
            FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_U:   enc_word = {imm[31:12], rd, opcode};
            FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_R:   enc_word = {1'b0, f7b5, 4'b0, mul, rs2, rs1, funct3, rd, opcode};
            default: fmt_legal = 1'b0;
        endcase
    end

    // live holds in_ready low until the first edge after reset release
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = live & ~full;
    assign accept    = in_valid & in_ready;
    assign push      = accept & fmt_legal & ~flush;
    assign pop       = ~empty & out_ready & ~flush;
    assign out_valid = ~empty;
    assign out_instr = empty ? 32'h0 : mem[rd_ptr];
    assign out_addr  = BASE_ADDR + {14'b0, pop_count, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_count <= '0;
            err       <= 1'b0;
        end else begin
            live <= 1'b1;
            err  <= accept & ~fmt_legal & ~flush;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                pop_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + ONE_PTR;
                if (pop) begin
                    rd_ptr    <= rd_ptr + ONE_PTR;
                    pop_count <= pop_count + 16'd1;
                end
                if (push && !pop)
                    count <= count + ONE_CNT;
                else if (pop && !push)
                    count <= count - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_word;
    end

endmodule
